instr_reg_scheduler: RTL and testbench

// - Front-end controller for instr_register: arbitrates two instruction requesters (round-robin),

---
 rtl/instr_register_pkg.sv | 31 +++
 rtl/instr_reg_scheduler_if.sv | 39 +++
 rtl/rr_arbiter2.sv | 47 ++++
 rtl/instr_reg_scheduler.sv | 126 ++++++++++++
 tb/tb_instr_reg_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its front-end scheduler: instruction encoding,
// queue addressing, and the requester id stored alongside each queued entry.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;

  typedef logic req_id_t;

  localparam int IRQ_DEPTH = 32;

endpackage

// File: rtl/instr_reg_scheduler_if.sv
// Requester and consumer handshakes of the scheduler. The master side is the environment
// (two requesters plus the downstream consumer), the slave side is the scheduler.
interface instr_reg_scheduler_if;
  import instr_register_pkg::*;

  logic         req0_valid;
  logic         req0_ready;
  opcode_t      req0_opcode;
  operand_t     req0_op_a;
  operand_t     req0_op_b;

  logic         req1_valid;
  logic         req1_ready;
  opcode_t      req1_opcode;
  operand_t     req1_op_a;
  operand_t     req1_op_b;

  logic         issue_valid;
  logic         issue_ready;
  instruction_t issue_word;
  req_id_t      issue_src;

  modport master (
    output req0_valid, req0_opcode, req0_op_a, req0_op_b,
    output req1_valid, req1_opcode, req1_op_a, req1_op_b,
    output issue_ready,
    input  req0_ready, req1_ready,
    input  issue_valid, issue_word, issue_src
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_op_a, req0_op_b,
    input  req1_valid, req1_opcode, req1_op_a, req1_op_b,
    input  issue_ready,
    output req0_ready, req1_ready,
    output issue_valid, issue_word, issue_src
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win the last accepted
// grant wins; the history only advances when a grant is actually issued.
module rr_arbiter2
  import instr_register_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t    last_grant_q;
  req_id_t    last_grant_d;
  logic [1:0] req_m;

  always_comb begin
    req_m        = req & {2{en}};
    grant        = 2'b00;
    grant_id     = 1'b0;
    last_grant_d = last_grant_q;
    case (req_m)
      2'b01: begin
        grant    = 2'b01;
        grant_id = 1'b0;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        grant_id = ~last_grant_q;
        grant    = grant_id ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
    if (|grant) last_grant_d = grant_id;
  end

  // Resetting to 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Front-end for instr_register: arbitrates two requesters into the register used as a
// circular queue, then issues entries in write order with the id of their requester.
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int DEPTH = IRQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  instr_reg_scheduler_if.slave bus,
  output logic                 load_en,
  output address_t             write_pointer,
  output opcode_t              opcode,
  output operand_t             operand_a,
  output operand_t             operand_b,
  output address_t             read_pointer,
  input  instruction_t         instruction_word,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  address_t         wr_ptr_q, wr_ptr_d;
  address_t         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  req_id_t          src_tag_q [DEPTH];
  req_id_t          src_tag_d [DEPTH];

  logic       cand_en;
  logic       accept;
  logic       pop;
  logic [1:0] grant;
  req_id_t    grant_id;

  // While reset is asserted the visible status reflects the post-reset state immediately.
  always_comb begin
    full          = !reset && (count_q == FULL_CNT);
    empty         = reset || (count_q == '0);
    count         = reset ? '0 : count_q;
    write_pointer = reset ? '0 : wr_ptr_q;
    read_pointer  = reset ? '0 : rd_ptr_q;
    cand_en       = !full && !flush && !reset;
  end

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({bus.req1_valid, bus.req0_valid}),
    .en       (cand_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign accept          = |grant;
  assign load_en         = accept;
  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.issue_valid = !empty && !flush;
  assign bus.issue_word  = instruction_word;
  assign bus.issue_src   = src_tag_q[rd_ptr_q];
  assign pop             = bus.issue_valid && bus.issue_ready;

  always_comb begin
    opcode    = ZERO;
    operand_a = '0;
    operand_b = '0;
    if (accept) begin
      if (grant_id) begin
        opcode    = bus.req1_opcode;
        operand_a = bus.req1_op_a;
        operand_b = bus.req1_op_b;
      end else begin
        opcode    = bus.req0_opcode;
        operand_a = bus.req0_op_a;
        operand_b = bus.req0_op_b;
      end
    end
  end

  // Pointers wrap through the natural width of address_t, which spans exactly DEPTH slots.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    src_tag_d = src_tag_q;
    if (accept) src_tag_d[wr_ptr_q] = grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tags are payload: only slots between head and tail are ever read, so no reset needed.
  always_ff @(posedge clk) begin
    src_tag_q <= src_tag_d;
  end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed and randomized bench for instr_reg_scheduler against a queue-based reference model;
// the bench also plays the instr_register array the scheduler controls.
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;

  typedef struct {
    opcode_t  opc;
    operand_t a;
    operand_t b;
    req_id_t  src;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         load_en;
  address_t     write_pointer;
  address_t     read_pointer;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  instruction_t instruction_word;
  logic [5:0]   count;
  logic         full;
  logic         empty;

  instr_reg_scheduler_if bus ();

  instr_reg_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .bus              (bus),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  always #5 clk = ~clk;

  function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
    result_t ra;
    result_t rb;
    ra = a;
    rb = b;
    case (o)
      PASSA:   return ra;
      PASSB:   return rb;
      ADD:     return ra + rb;
      SUB:     return ra - rb;
      MULT:    return ra * rb;
      default: return '0;
    endcase
  endfunction

  // Behaviour of instr_register: write on load_en, combinational read at read_pointer.
  instruction_t mem [DEPTH];
  always @(posedge clk) begin
    if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b, calc(opcode, operand_a, operand_b)};
  end
  assign instruction_word = mem[read_pointer];

  int      n_chk  = 0;
  int      n_fail = 0;
  ent_t    q[$];
  req_id_t last_grant = 1'b1;
  int      wr = 0;
  int      rd = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rnd_data();
    bus.req0_opcode = opcode_t'($urandom_range(0, 7));
    bus.req0_op_a   = operand_t'($urandom);
    bus.req0_op_b   = operand_t'($urandom);
    bus.req1_opcode = opcode_t'($urandom_range(0, 7));
    bus.req1_op_a   = operand_t'($urandom);
    bus.req1_op_b   = operand_t'($urandom);
  endtask

  // Check one cycle against the model, cross the clock edge, advance the model.
  task automatic step();
    bit      can, v0, v1, acc, iv, pop;
    req_id_t id;
    ent_t    e;
    #1;
    can = (q.size() < DEPTH) && !flush;
    v0  = bus.req0_valid && can;
    v1  = bus.req1_valid && can;
    acc = !reset && (v0 || v1);
    id  = (v0 && v1) ? ~last_grant : (v1 ? 1'b1 : 1'b0);
    iv  = !reset && (q.size() != 0) && !flush;
    pop = iv && bus.issue_ready;
    e.opc = id ? bus.req1_opcode : bus.req0_opcode;
    e.a   = id ? bus.req1_op_a   : bus.req0_op_a;
    e.b   = id ? bus.req1_op_b   : bus.req0_op_b;
    e.src = id;
    chk("load_en",     64'(load_en),        64'(acc));
    chk("req0_ready",  64'(bus.req0_ready), 64'(acc && !id));
    chk("req1_ready",  64'(bus.req1_ready), 64'(acc && id));
    chk("issue_valid", 64'(bus.issue_valid), 64'(iv));
    chk("count",       64'(count),          reset ? 64'(0) : 64'(q.size()));
    chk("empty",       64'(empty),          64'(reset || q.size() == 0));
    chk("full",        64'(full),           64'(!reset && q.size() == DEPTH));
    chk("write_ptr",   64'(write_pointer),  reset ? 64'(0) : 64'(wr));
    chk("read_ptr",    64'(read_pointer),   reset ? 64'(0) : 64'(rd));
    if (!reset) begin
      chk("opcode",    64'(opcode),         acc ? 64'(e.opc) : 64'(ZERO));
      chk("operand_a", 64'(operand_a),      acc ? 64'(e.a) : 64'(0));
      chk("operand_b", 64'(operand_b),      acc ? 64'(e.b) : 64'(0));
    end
    if (iv) begin
      chk("issue_opc",  64'(bus.issue_word.opc),      64'(q[0].opc));
      chk("issue_op_a", 64'(bus.issue_word.op_a),     64'(q[0].a));
      chk("issue_op_b", 64'(bus.issue_word.op_b),     64'(q[0].b));
      chk("issue_res",  64'(bus.issue_word.rezultat), 64'(calc(q[0].opc, q[0].a, q[0].b)));
      chk("issue_src",  64'(bus.issue_src),           64'(q[0].src));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      last_grant = 1'b1;
      wr = 0;
      rd = 0;
    end else if (flush) begin
      q.delete();
      wr = 0;
      rd = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        rd = (rd + 1) % DEPTH;
      end
      if (acc) begin
        q.push_back(e);
        wr = (wr + 1) % DEPTH;
        last_grant = id;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.req0_valid  = 1'b1;
    bus.req1_valid  = 1'b0;
    bus.issue_ready = 1'b0;
    rnd_data();

    // Reset held two cycles with a pending request
    step();
    step();

    // Single request req0 {ADD, 5, 3}, then drain it
    reset = 1'b0;
    bus.req0_opcode = ADD;
    bus.req0_op_a   = 32'sd5;
    bus.req0_op_b   = 32'sd3;
    step();
    bus.req0_valid = 1'b0;
    step();
    bus.issue_ready = 1'b1;
    step();
    step();

    // Both requesters every cycle, consumer stalled, until full
    bus.issue_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 34; i++) begin
      rnd_data();
      step();
    end

    // One pop while full, then the freed slot is refilled
    bus.issue_ready = 1'b1;
    rnd_data();
    step();
    bus.issue_ready = 1'b0;
    rnd_data();
    step();
    rnd_data();
    step();

    // Flush, queue 3 entries, stall the consumer, then drain in order
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step();
    end
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Fill to 7, flush with requests pending, then the next accept lands in slot 0
    bus.issue_ready = 1'b0;
    bus.req0_valid  = 1'b1;
    bus.req1_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rnd_data();
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.req0_valid = 1'b0;
    step();
    bus.req1_valid = 1'b1;
    rnd_data();
    step();
    bus.req1_valid = 1'b0;
    step();

    // Randomized traffic: slow consumer first so the queue fills, then a fast one
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 149) == 0);
      flush           = ($urandom_range(0, 59) == 0);
      bus.req0_valid  = ($urandom_range(0, 99) < 70);
      bus.req1_valid  = ($urandom_range(0, 99) < 70);
      bus.issue_ready = ($urandom_range(0, 99) < ((i < 200) ? 20 : 80));
      rnd_data();
      step();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
